// File: rtl/sram_load_sequencer.sv
// SRAM load sequencer: one image load per detection start, then round-robin
// coefficient bank loads on request, each transfer guarded by a watchdog.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for start_detecting
// S_LOAD_IMAGE | start_sram pulse for the image transfer
// S_WAIT_IMAGE | image transfer in flight, watchdog running
// S_DONE_IMAGE | image transfer complete pulse
// S_COEF_IDLE  | waiting for request_coef or done_processing
// S_LOAD_COEF  | start_sram pulse for coefficient bank bank_sel
// S_WAIT_COEF  | coefficient transfer in flight, watchdog running
// S_COEF_DONE  | coefficient transfer complete pulse, advance bank next
// S_ERROR      | watchdog expired, held until abort
module sram_load_sequencer #(
  parameter int NUM_COEF_BANKS = 4,
  parameter int BANK_W         = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 11
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_detecting,
  input  logic              request_coef,
  input  logic              done_processing,
  input  logic              abort,
  input  logic              sram_done,
  output logic              start_sram,
  output logic              n_coef_image,
  output logic [BANK_W-1:0] bank_sel,
  output logic              image_weights_loaded,
  output logic              last_bank,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_IMAGE = 4'd1,
    S_WAIT_IMAGE = 4'd2,
    S_DONE_IMAGE = 4'd3,
    S_COEF_IDLE  = 4'd4,
    S_LOAD_COEF  = 4'd5,
    S_WAIT_COEF  = 4'd6,
    S_COEF_DONE  = 4'd7,
    S_ERROR      = 4'd8
  } state_t;

  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_COEF_BANKS - 1);
  // With the watchdog disabled the compare value is irrelevant; keep it legal.
  localparam logic [TMR_W-1:0]  WDOG_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit                WDOG_EN   = (TIMEOUT_CYCLES > 0);

  state_t            state, state_nxt;
  logic [BANK_W-1:0] bank, bank_nxt;
  logic [TMR_W-1:0]  wdog, wdog_nxt;
  logic              in_wait, nxt_wait, wdog_expired;

  // State, bank pointer and watchdog registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
      bank  <= '0;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      bank  <= bank_nxt;
      wdog  <= wdog_nxt;
    end
  end

  // Next state, bank pointer and watchdog; abort overrides everything.
  always_comb begin
    state_nxt    = state;
    bank_nxt     = bank;
    wdog_nxt     = '0;
    in_wait      = (state == S_WAIT_IMAGE) || (state == S_WAIT_COEF);
    wdog_expired = WDOG_EN && (wdog == WDOG_LAST);

    unique case (state)
      S_IDLE:       if (start_detecting) state_nxt = S_LOAD_IMAGE;
      S_LOAD_IMAGE: state_nxt = S_WAIT_IMAGE;
      S_WAIT_IMAGE: begin
        if (sram_done)         state_nxt = S_DONE_IMAGE;
        else if (wdog_expired) state_nxt = S_ERROR;
      end
      S_DONE_IMAGE: state_nxt = S_COEF_IDLE;
      S_COEF_IDLE: begin
        if (request_coef) begin
          state_nxt = S_LOAD_COEF;
        end else if (done_processing) begin
          state_nxt = S_IDLE;
          bank_nxt  = '0;
        end
      end
      S_LOAD_COEF:  state_nxt = S_WAIT_COEF;
      S_WAIT_COEF: begin
        if (sram_done)         state_nxt = S_COEF_DONE;
        else if (wdog_expired) state_nxt = S_ERROR;
      end
      S_COEF_DONE: begin
        state_nxt = S_COEF_IDLE;
        bank_nxt  = (bank == LAST_BANK) ? '0 : bank + BANK_W'(1);
      end
      S_ERROR:      state_nxt = S_ERROR;
      default:      state_nxt = S_IDLE;
    endcase

    if (abort) begin
      state_nxt = S_IDLE;
      bank_nxt  = '0;
    end

    // Counter only advances while staying in a WAIT state; entering WAIT
    // from LOAD starts it at zero, and it saturates rather than wrapping.
    nxt_wait = (state_nxt == S_WAIT_IMAGE) || (state_nxt == S_WAIT_COEF);
    if (in_wait && nxt_wait)
      wdog_nxt = (wdog == {TMR_W{1'b1}}) ? wdog : wdog + TMR_W'(1);
  end

  // Moore output decode from the current state.
  always_comb begin
    start_sram           = 1'b0;
    n_coef_image         = 1'b0;
    image_weights_loaded = 1'b0;
    last_bank            = 1'b0;
    timeout_err          = 1'b0;
    busy                 = (state != S_IDLE) && (state != S_ERROR);
    unique case (state)
      S_LOAD_IMAGE: begin
        start_sram   = 1'b1;
        n_coef_image = 1'b1;
      end
      S_WAIT_IMAGE: n_coef_image = 1'b1;
      S_DONE_IMAGE: image_weights_loaded = 1'b1;
      S_LOAD_COEF:  start_sram = 1'b1;
      S_COEF_DONE: begin
        image_weights_loaded = 1'b1;
        last_bank            = (bank == LAST_BANK);
      end
      S_ERROR:      timeout_err = 1'b1;
      default:      ;
    endcase
  end

  assign bank_sel = bank;

endmodule

// File: doc/sram_load_sequencer.md
# sram_load_sequencer

Parametrised SRAM load sequencer sitting between the detection control FSM and the SRAM transfer engine. On `start_detecting` it issues one image load. It then serves coefficient-load requests across `NUM_COEF_BANKS` banks, selecting banks in round-robin order with wrap-around. Every SRAM transfer is bounded by a watchdog timeout, and an `abort` input unconditionally returns the block to idle.

## Interface
- `NUM_COEF_BANKS`, 4: number of coefficient banks (≥2).
- `BANK_W`, 2: width of `bank_sel`; must satisfy 2^BANK_W ≥ NUM_COEF_BANKS.
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent in a WAIT state; 0 disables the watchdog.
- `TMR_W`, 11: watchdog counter width; must hold TIMEOUT_CYCLES-1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `start_detecting`  in  1  begin image load; sampled only in IDLE.
- `request_coef`  in  1  load next coefficient bank; sampled only in COEF_IDLE.
- `done_processing`  in  1  end of frame; sampled only in COEF_IDLE.
- `abort`  in  1  synchronous abort, highest priority, all states.
- `sram_done`  in  1  transfer complete; sampled only in WAIT_IMAGE / WAIT_COEF.
- `start_sram`  out  1  one-cycle transfer-start pulse.
- `n_coef_image`  out  1  1 = image transfer, 0 = coefficient transfer.
- `bank_sel`  out  BANK_W  coefficient bank for the current or next transfer.
- `image_weights_loaded`  out  1  one-cycle pulse when a transfer completes.
- `last_bank`  out  1  one-cycle pulse that accompanies completion of bank NUM_COEF_BANKS-1.
- `busy`  out  1  high in every state except IDLE and ERROR.
- `timeout_err`  out  1  high while in ERROR.

## Operation
- States (4-bit encoding): IDLE, LOAD_IMAGE, WAIT_IMAGE, DONE_IMAGE, COEF_IDLE, LOAD_COEF, WAIT_COEF, COEF_DONE, ERROR.
- Transitions:
  - IDLE→LOAD_IMAGE on `start_detecting`.
  - LOAD_IMAGE→WAIT_IMAGE unconditionally.
  - WAIT_IMAGE→DONE_IMAGE on `sram_done`.
  - DONE_IMAGE→COEF_IDLE unconditionally.
  - COEF_IDLE→LOAD_COEF on `request_coef`, else →IDLE on `done_processing`.
  - LOAD_COEF→WAIT_COEF unconditionally.
  - WAIT_COEF→COEF_DONE on `sram_done`.
  - COEF_DONE→COEF_IDLE unconditionally.
  - WAIT_x→ERROR on timeout.
  - ERROR→IDLE only on `abort`.
- `abort` high in any state: next state is IDLE, `bank_sel` is cleared to 0, and the watchdog is cleared.
- Priorities:
  - `abort` over everything else.
  - `request_coef` over `done_processing`.
  - `sram_done` over timeout in the same cycle.
- Outputs are decoded combinationally from state (Moore):
  - LOAD_IMAGE: `start_sram`=1, `n_coef_image`=1.
  - WAIT_IMAGE: `n_coef_image`=1.
  - DONE_IMAGE and COEF_DONE: `image_weights_loaded`=1.
  - LOAD_COEF: `start_sram`=1.
  - COEF_DONE with `bank_sel`==NUM_COEF_BANKS-1: `last_bank`=1.
  - ERROR: `timeout_err`=1.
  - All other outputs are 0.
- Bank pointer:
  - Registered.
  - Increments on the COEF_DONE→COEF_IDLE edge, wrapping NUM_COEF_BANKS-1→0.
  - Cleared to 0 on COEF_IDLE→IDLE, on abort, and on reset.
  - Held at all other times.
  - Stable throughout LOAD_COEF/WAIT_COEF.
- Watchdog:
  - Cleared in every state other than WAIT_IMAGE/WAIT_COEF.
  - Increments each WAIT cycle without `sram_done`.
  - When it equals TIMEOUT_CYCLES-1 with `sram_done`=0, the next state is ERROR.
  - Counts saturate and never wrap.
- Ignored inputs:
  - `start_detecting` outside IDLE.
  - `sram_done` outside the WAIT states.
  - `request_coef`/`done_processing` outside COEF_IDLE.

## Timing
- Reset values:
  - State IDLE, `bank_sel`=0, watchdog=0.
  - `start_sram`, `n_coef_image`, `image_weights_loaded`, `last_bank`, `busy`, `timeout_err` all 0.
- Latencies:
  - `start_detecting` sampled at edge k → `start_sram` high during cycle k+1, exactly one cycle.
  - `sram_done` sampled at edge k in WAIT → `image_weights_loaded` high during cycle k+1, one cycle.
  - `request_coef` at edge k → `start_sram` during cycle k+1.
- Minimum image-load round trip: 4 cycles, with `sram_done` high on the first WAIT cycle.
- Maximum WAIT dwell: TIMEOUT_CYCLES cycles; ERROR is entered on the following cycle.
- `n_rst` asserted mid-transfer: outputs drop to reset values immediately (asynchronously); no `start_sram` is issued after release until a new `start_detecting`.
- `abort` and `sram_done` in the same WAIT cycle: IDLE, no completion pulse.

## Test plan
- Reset, then `start_detecting` pulse; `sram_done` on the 3rd WAIT cycle → `start_sram`=1 for 1 cycle with `n_coef_image`=1; `image_weights_loaded` pulse; state COEF_IDLE, `busy`=1.
- NUM_COEF_BANKS=4: five `request_coef`/`sram_done` rounds → `bank_sel` reads 0,1,2,3,0; `last_bank` pulses only on the 4th completion.
- TIMEOUT_CYCLES=8, `sram_done` never asserted in WAIT_COEF → ERROR after 8 WAIT cycles, `timeout_err`=1, `busy`=0; `abort` → IDLE, `bank_sel`=0.
- `sram_done` asserted on the exact cycle the watchdog reaches 7 → COEF_DONE, no ERROR.
- `request_coef` and `done_processing` together in COEF_IDLE → LOAD_COEF. `done_processing` alone → IDLE, `bank_sel` cleared from 2 to 0.
- `n_rst` low during WAIT_IMAGE with `bank_sel`=1 → all outputs 0 immediately. After release, stray `sram_done`/`request_coef` pulses → no `start_sram`, no `image_weights_loaded`.
